div_wb_buffer: RTL and testbench
================================

DIV_WB_BUFFER -- requirements
Module: div_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning result entries held; legal values are powers of two, 2..16.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mispredict  in  1  branch-mispredict flush strobe.
REQ-005 SHALL have port flush_mask  in  `ROB_LEN  ROB entries killed when mispredict=1.
REQ-006 SHALL have port in_valid  in  1  result from divider output stage.
REQ-007 SHALL have port in_rob_idx  in  $clog2(`ROB_LEN)  ROB index of incoming result.
REQ-008 SHALL have port in_rd  in  7  destination physical register.
REQ-009 SHALL have port in_data  in  32  divide/remainder result.
REQ-010 SHALL have port in_ready  out  1  drives divider div_i_ready; low stalls the whole divider pipeline.
REQ-011 SHALL have port wb_valid  out  1  result offered to writeback/CDB arbiter.
REQ-012 SHALL have ports wb_rob_idx, wb_rd, wb_data  out  $clog2(`ROB_LEN)/7/32  offered result fields.
REQ-013 SHALL have port wb_ready  in  1  arbiter grant; a transfer occurs when wb_valid and wb_ready are both high.

Function
REQ-014 SHALL be a circular FIFO of DEPTH slots: head pointer, tail pointer, occupancy count 0..DEPTH, and one live bit per slot.
REQ-015 SHALL drive in_ready = (count != DEPTH), decoded from registered state only, with no combinational path from wb_ready or in_valid.
REQ-016 SHALL push on posedge when in_valid & in_ready: slot[tail] <= fields, live <= ~(mispredict & flush_mask[in_rob_idx]), tail+1 modulo DEPTH, count+1.
REQ-017 SHALL ignore in_valid when in_ready=0; no slot or counter change.
REQ-018 SHALL make a pushed entry visible on wb_valid no earlier than the next cycle (minimum latency 1, no input-to-output bypass).
REQ-019 SHALL drive wb_valid = (count!=0) & live[head] & ~(mispredict & flush_mask[slot[head].rob_idx]); wb_* fields come from slot[head].
REQ-020 SHALL pop head (head+1, count-1) on transfer, or silently when count!=0 and head slot is dead or flushed that cycle; at most one pop per cycle.
REQ-021 SHALL, on a cycle with mispredict=1, clear live for every slot whose rob_idx has flush_mask bit set; other slots keep order and contents.
REQ-022 SHALL keep wb_valid and wb_* stable while wb_valid=1 and wb_ready=0, except when the head is flushed.
REQ-023 SHALL apply simultaneous push and pop in the same cycle: count unchanged, both pointers advance.
REQ-024 SHALL allow push and pop in the same cycle at count=DEPTH-1, then reach full. When full, in_ready=0 even if a pop occurs that cycle.
REQ-025 SHALL wrap both pointers from DEPTH-1 to 0 without a bubble.

Reset
REQ-026 SHALL, while rst=0 (asynchronously), force head=0, tail=0, count=0, all live=0; therefore wb_valid=0 and in_ready=1.
REQ-027 SHALL hold slot data fields unreset. They are don't-care while dead.
REQ-028 SHALL discard all contents on reset mid-operation; no partial writeback after rst deasserts.

Structure
REQ-029 SHALL take ROB_LEN from the shared config include; the slot struct type (rob_idx, rd, data) SHALL live in the shared CPU package for reuse by other FU writeback buffers.
REQ-030 SHALL be a single module with no sub-module; the flush-aware FIFO is not a generic FIFO.

Verification
REQ-031 SHALL test basic flow: push rob 3/rd 5/data 0x0000_0007 with wb_ready=1 -> wb_valid next cycle with those fields; count returns to 0.
REQ-032 SHALL test backpressure: DEPTH=4, wb_ready=0, push 4 results -> in_ready=0 after 4th; 5th in_valid ignored; release wb_ready -> 4 results in push order, in_ready=1 after first pop.
REQ-033 SHALL test flush in queue: entries rob 1,2,3 queued, mispredict with flush_mask bit 2 -> writeback order 1,3; rob 2 never on wb_valid.
REQ-034 SHALL test flush on input: in_valid rob 6 in the same cycle as mispredict with flush_mask bit 6 -> slot consumed, never written back.
REQ-035 SHALL test hold and wrap: 10 pushes with wb_ready toggling each cycle -> outputs stable while stalled; pointer wrap without loss or reorder.
REQ-036 SHALL test async reset: rst=0 mid-cycle with 3 entries -> wb_valid=0 and in_ready=1 immediately, no output after release.

Source files
------------

// File: rtl/div_wb_buffer_pkg.sv
// Shared CPU package slice used by the functional-unit writeback buffers.
// ROB_LEN comes from the shared CPU configuration macro. The default below
// is used only when that configuration has not already been compiled in.
// wb_slot_t is the result record (rob_idx, rd, data) that every FU
// writeback buffer stores and forwards to the CDB arbiter.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

package div_wb_buffer_pkg;

  localparam int unsigned ROB_LEN   = `ROB_LEN;
  localparam int unsigned ROB_IDX_W = $clog2(ROB_LEN);
  localparam int unsigned RD_W      = 7;
  localparam int unsigned DATA_W    = 32;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [RD_W-1:0]      rd;
    logic [DATA_W-1:0]    data;
  } wb_slot_t;

endpackage

// File: rtl/div_wb_buffer.sv
// Divider writeback buffer: a flush-aware circular FIFO that sits between the
// divider output stage and the writeback/CDB arbiter.
//
// Ports
//   clk        : clock. All state changes on the rising edge.
//   rst        : asynchronous, active-low reset. Empties the buffer.
//   mispredict : branch-mispredict flush strobe.
//   flush_mask : ROB entries killed while mispredict is high.
//   in_valid   : result presented by the divider output stage.
//   in_rob_idx : ROB index of the incoming result.
//   in_rd      : destination physical register of the incoming result.
//   in_data    : divide or remainder result.
//   in_ready   : buffer not full. When low, it stalls the divider pipeline.
//                It depends on registered state only.
//   wb_valid   : head result offered to the arbiter.
//   wb_rob_idx : ROB index of the offered result.
//   wb_rd      : destination register of the offered result.
//   wb_data    : data of the offered result.
//   wb_ready   : arbiter grant. A transfer occurs when wb_valid & wb_ready.
//
// DEPTH must be a power of two in the range 2..16, so that the pointers wrap
// naturally.
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module div_wb_buffer
  import div_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mispredict,
  input  logic [`ROB_LEN-1:0]  flush_mask,
  input  logic                 in_valid,
  input  logic [ROB_IDX_W-1:0] in_rob_idx,
  input  logic [RD_W-1:0]      in_rd,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 wb_valid,
  output logic [ROB_IDX_W-1:0] wb_rob_idx,
  output logic [RD_W-1:0]      wb_rd,
  output logic [DATA_W-1:0]    wb_data,
  input  logic                 wb_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] live_q, live_d;
  wb_slot_t         slots_q [DEPTH];

  wb_slot_t head_slot;
  logic     not_empty;
  logic     head_flush;
  logic     push;
  logic     pop;
  logic     xfer;

  always_comb begin
    head_slot  = slots_q[head_q];
    not_empty  = (count_q != '0);
    head_flush = mispredict & flush_mask[head_slot.rob_idx];

    in_ready   = (count_q != FULL_CNT);
    wb_valid   = not_empty & live_q[head_q] & ~head_flush;
    wb_rob_idx = head_slot.rob_idx;
    wb_rd      = head_slot.rd;
    wb_data    = head_slot.data;

    push = in_valid & in_ready;
    xfer = wb_valid & wb_ready;
    // A dead or flushed head is dropped without being offered. This lets
    // killed entries drain at one per cycle, the same rate as real transfers.
    pop  = not_empty & (xfer | ~live_q[head_q] | head_flush);
  end

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live_d[i] = live_q[i] & ~(mispredict & flush_mask[slots_q[i].rob_idx]);
    end
    // head == tail with both a push and a pop is impossible. An empty buffer
    // never pops and a full buffer never pushes, so these updates never collide.
    if (pop) begin
      live_d[head_q] = 1'b0;
    end
    if (push) begin
      live_d[tail_q] = ~(mispredict & flush_mask[in_rob_idx]);
    end

    head_d = pop  ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;

    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // The slot payload has no reset. It is meaningful only while its live bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      slots_q[tail_q] <= '{rob_idx: in_rob_idx, rd: in_rd, data: in_data};
    end
  end

endmodule

// File: tb/tb_div_wb_buffer.sv
module tb_div_wb_buffer;
  import div_wb_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 mispredict = 1'b0;
  logic [ROB_LEN-1:0]   flush_mask = '0;
  logic                 in_valid = 1'b0;
  logic [ROB_IDX_W-1:0] in_rob_idx = '0;
  logic [RD_W-1:0]      in_rd = '0;
  logic [DATA_W-1:0]    in_data = '0;
  logic                 in_ready;
  logic                 wb_valid;
  logic [ROB_IDX_W-1:0] wb_rob_idx;
  logic [RD_W-1:0]      wb_rd;
  logic [DATA_W-1:0]    wb_data;
  logic                 wb_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .mispredict (mispredict),
    .flush_mask (flush_mask),
    .in_valid   (in_valid),
    .in_rob_idx (in_rob_idx),
    .in_rd      (in_rd),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wb_valid   (wb_valid),
    .wb_rob_idx (wb_rob_idx),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input int r, input int d, input int v);
    in_valid   = 1'b1;
    in_rob_idx = ROB_IDX_W'(r);
    in_rd      = RD_W'(d);
    in_data    = DATA_W'(v);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wb_valid: got %b want 0", wb_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_basic();
    wb_ready = 1'b1;
    push_one(3, 5, 32'h0000_0007);
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_bypass: got %b want 0", wb_valid);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_rob_idx, wb_rd, wb_data} !== {1'b1, 4'd3, 7'd5, 32'h0000_0007}) begin
      errors++;
      $display("FAIL basic_out: got v=%b rob=%0d rd=%0d data=%h want v=1 rob=3 rd=5 data=00000007",
               wb_valid, wb_rob_idx, wb_rd, wb_data);
    end
    cyc();
    #1;
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL basic_empty: got v=%b rdy=%b want v=0 rdy=1", wb_valid, in_ready);
    end
    wb_ready = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(i, 10 + i, 32'h100 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready_pre%0d: got %b want 1", i, in_ready);
      end
      cyc();
    end
    push_one(9, 99, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: got in_ready=%b want 0", in_ready);
    end
    checks++;
    if ({wb_valid, wb_rob_idx} !== {1'b1, 4'd0}) begin
      errors++;
      $display("FAIL bp_head: got v=%b rob=%0d want v=1 rob=0", wb_valid, wb_rob_idx);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_still_full: got in_ready=%b want 0", in_ready);
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({wb_valid, wb_rob_idx, wb_rd, wb_data} !==
          {1'b1, ROB_IDX_W'(i), RD_W'(10 + i), DATA_W'(32'h100 + i)}) begin
        errors++;
        $display("FAIL bp_order%0d: got v=%b rob=%0d rd=%0d data=%h want v=1 rob=%0d rd=%0d data=%h",
                 i, wb_valid, wb_rob_idx, wb_rd, wb_data, i, 10 + i, 32'h100 + i);
      end
      if (i == 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_after_pop: got %b want 1", in_ready);
        end
      end
      cyc();
    end
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got wb_valid=%b want 0", wb_valid);
    end
    wb_ready = 1'b0;
    cyc();
  endtask

  task automatic test_flush_queue();
    int   got[$];
    logic seen2;
    seen2 = 1'b0;
    wb_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push_one(i, i, 32'h11 * i);
      cyc();
    end
    in_valid   = 1'b0;
    mispredict = 1'b1;
    flush_mask = ROB_LEN'(1) << 2;
    #1;
    checks++;
    if ({wb_valid, wb_rob_idx} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL fq_head_kept: got v=%b rob=%0d want v=1 rob=1", wb_valid, wb_rob_idx);
    end
    cyc();
    mispredict = 1'b0;
    flush_mask = '0;
    wb_ready   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (wb_valid && wb_ready) got.push_back(int'(wb_rob_idx));
      if (wb_valid && wb_rob_idx == 4'd2) seen2 = 1'b1;
      cyc();
    end
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL fq_count: got %0d writebacks want 2", got.size());
    end else begin
      checks++;
      if (got[0] != 1 || got[1] != 3) begin
        errors++;
        $display("FAIL fq_order: got %0d,%0d want 1,3", got[0], got[1]);
      end
    end
    checks++;
    if (seen2 !== 1'b0) begin
      errors++;
      $display("FAIL fq_rob2_seen: got %b want 0", seen2);
    end
    // The head is flushed while it is being offered, so wb_valid must drop in that same cycle.
    wb_ready = 1'b0;
    push_one(5, 50, 32'h55);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_rob_idx} !== {1'b1, 4'd5}) begin
      errors++;
      $display("FAIL fq_head5: got v=%b rob=%0d want v=1 rob=5", wb_valid, wb_rob_idx);
    end
    mispredict = 1'b1;
    flush_mask = ROB_LEN'(1) << 5;
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL fq_head_flush_comb: got %b want 0", wb_valid);
    end
    cyc();
    mispredict = 1'b0;
    flush_mask = '0;
    #1;
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL fq_head_dropped: got v=%b rdy=%b want v=0 rdy=1", wb_valid, in_ready);
    end
    cyc();
  endtask

  task automatic test_flush_input();
    logic seen;
    seen = 1'b0;
    wb_ready   = 1'b1;
    push_one(6, 60, 32'h66);
    mispredict = 1'b1;
    flush_mask = ROB_LEN'(1) << 6;
    cyc();
    in_valid   = 1'b0;
    mispredict = 1'b0;
    flush_mask = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (wb_valid) seen = 1'b1;
      cyc();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL fi_never_valid: got %b want 0", seen);
    end
    push_one(7, 70, 32'h77);
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_rob_idx, wb_data} !== {1'b1, 4'd7, 32'h77}) begin
      errors++;
      $display("FAIL fi_next: got v=%b rob=%0d data=%h want v=1 rob=7 data=00000077",
               wb_valid, wb_rob_idx, wb_data);
    end
    cyc();
    wb_ready = 1'b0;
    cyc();
  endtask

  task automatic test_hold_wrap();
    int                   sent = 0;
    int                   rcvd = 0;
    logic                 prev_stall = 1'b0;
    logic [ROB_IDX_W-1:0] p_rob;
    logic [RD_W-1:0]      p_rd;
    logic [DATA_W-1:0]    p_data;
    p_rob  = '0;
    p_rd   = '0;
    p_data = '0;
    for (int c = 0; c < 60 && rcvd < 10; c++) begin
      wb_ready = (c % 2) == 1;
      if (sent < 10 && in_ready) push_one(sent, 40 + sent, 32'hA000 + sent);
      else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        checks++;
        if ({wb_valid, wb_rob_idx, wb_rd, wb_data} !== {1'b1, p_rob, p_rd, p_data}) begin
          errors++;
          $display("FAIL hw_hold: got v=%b rob=%0d data=%h want v=1 rob=%0d data=%h",
                   wb_valid, wb_rob_idx, wb_data, p_rob, p_data);
        end
      end
      if (wb_valid && wb_ready) begin
        checks++;
        if ({wb_rob_idx, wb_rd, wb_data} !== {ROB_IDX_W'(rcvd), RD_W'(40 + rcvd), DATA_W'(32'hA000 + rcvd)}) begin
          errors++;
          $display("FAIL hw_order%0d: got rob=%0d rd=%0d data=%h want rob=%0d rd=%0d data=%h",
                   rcvd, wb_rob_idx, wb_rd, wb_data, rcvd, 40 + rcvd, 32'hA000 + rcvd);
        end
        rcvd++;
      end
      prev_stall = wb_valid && !wb_ready;
      p_rob  = wb_rob_idx;
      p_rd   = wb_rd;
      p_data = wb_data;
      if (in_valid) sent++;
      cyc();
    end
    in_valid = 1'b0;
    wb_ready = 1'b0;
    checks++;
    if (rcvd != 10) begin
      errors++;
      $display("FAIL hw_count: got %0d want 10", rcvd);
    end
    #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL hw_empty: got wb_valid=%b want 0", wb_valid);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    logic seen;
    seen = 1'b0;
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_one(8 + i, 80 + i, 32'hB0 + i);
      cyc();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: got wb_valid=%b want 1", wb_valid);
    end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL ar_immediate: got v=%b rdy=%b want v=0 rdy=1", wb_valid, in_ready);
    end
    cyc();
    cyc();
    rst = 1'b1;
    wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (wb_valid) seen = 1'b1;
      cyc();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL ar_no_output: got %b want 0", seen);
    end
    wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush_queue();
    test_flush_input();
    test_hold_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
